// File: rtl/muldiv_iter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : muldiv_iter_if                                                   |
// | Purpose  : Request/response bundle for the iterative RV32M mul/div unit.    |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
interface muldiv_iter_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, funct3, rs1_val, rs2_val,
        input  busy, done, result
    );

    modport slave (
        input  start, funct3, rs1_val, rs2_val,
        output busy, done, result
    );
endinterface
`default_nettype wire

// File: rtl/muldiv_iter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : muldiv_iter                                                      |
// | Purpose  : Iterative RV32M multiply/divide, fixed XLEN+1 cycle latency.     |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module muldiv_iter #(
    parameter int XLEN = 32
) (
    input  logic          clk,
    input  logic          rst,
    muldiv_iter_if.slave  bus
);
    localparam int             CW       = $clog2(XLEN) + 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(XLEN - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            r_state;
    logic              r_busy;
    logic              r_done;
    logic [XLEN-1:0]   r_result;
    logic [CW-1:0]     r_cnt;
    logic [2:0]        r_op;
    logic [XLEN-1:0]   r_rs1;
    logic [XLEN-1:0]   r_opa;
    logic [XLEN-1:0]   r_opb;
    logic              r_neg;
    logic              r_neg_rem;
    logic [2*XLEN-1:0] r_prod;
    logic [XLEN-1:0]   r_rem;
    logic [XLEN-1:0]   r_quo;

    logic              w_a_sgn;
    logic              w_b_sgn;
    logic [XLEN-1:0]   w_a_mag;
    logic [XLEN-1:0]   w_b_mag;
    logic [XLEN:0]     w_sum;
    logic [XLEN:0]     w_trial;
    logic              w_ge;
    logic [XLEN-1:0]   w_diff;
    logic [XLEN-1:0]   w_rem_nxt;
    logic [2*XLEN-1:0] w_prod_fix;
    logic [XLEN-1:0]   w_quo_fix;
    logic [XLEN-1:0]   w_rem_fix;
    logic [XLEN-1:0]   w_result;

    // Operand signedness per op; unsigned ops and MUL use raw magnitudes.
    always_comb begin
        w_a_sgn = 1'b0;
        w_b_sgn = 1'b0;
        case (bus.funct3)
            3'b001, 3'b100, 3'b110: begin
                w_a_sgn = bus.rs1_val[XLEN-1];
                w_b_sgn = bus.rs2_val[XLEN-1];
            end
            3'b010:  w_a_sgn = bus.rs1_val[XLEN-1];
            default: ;
        endcase
        w_a_mag = w_a_sgn ? -bus.rs1_val : bus.rs1_val;
        w_b_mag = w_b_sgn ? -bus.rs2_val : bus.rs2_val;
    end

    // Both datapaths step every CALC cycle; FIX picks whichever the op needs.
    always_comb begin
        w_sum     = {1'b0, r_prod[2*XLEN-1:XLEN]} + (r_prod[0] ? {1'b0, r_opa} : '0);
        w_trial   = {r_rem, r_quo[XLEN-1]};
        w_ge      = (w_trial >= {1'b0, r_opb});
        w_diff    = w_trial[XLEN-1:0] - r_opb;
        w_rem_nxt = w_ge ? w_diff : w_trial[XLEN-1:0];
    end

    // A zero divisor magnitude means rs2 was zero; overflow falls out naturally.
    always_comb begin
        w_prod_fix = r_neg     ? -r_prod : r_prod;
        w_quo_fix  = r_neg     ? -r_quo  : r_quo;
        w_rem_fix  = r_neg_rem ? -r_rem  : r_rem;
        w_result   = '0;
        case (r_op)
            3'b000:                 w_result = w_prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: w_result = w_prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:         w_result = (r_opb == '0) ? '1 : w_quo_fix;
            default:                w_result = (r_opb == '0) ? r_rs1 : w_rem_fix;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_result  <= '0;
            r_cnt     <= '0;
            r_op      <= '0;
            r_rs1     <= '0;
            r_opa     <= '0;
            r_opb     <= '0;
            r_neg     <= 1'b0;
            r_neg_rem <= 1'b0;
            r_prod    <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_op      <= bus.funct3;
                        r_rs1     <= bus.rs1_val;
                        r_opa     <= w_a_mag;
                        r_opb     <= w_b_mag;
                        r_neg     <= w_a_sgn ^ w_b_sgn;
                        r_neg_rem <= w_a_sgn;
                        r_prod    <= {{XLEN{1'b0}}, w_b_mag};
                        r_rem     <= '0;
                        r_quo     <= w_a_mag;
                        r_cnt     <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_prod <= {w_sum, r_prod[XLEN-1:1]};
                    r_rem  <= w_rem_nxt;
                    r_quo  <= {r_quo[XLEN-2:0], w_ge};
                    r_cnt  <= r_cnt + CW'(1);
                    if (r_cnt == CNT_LAST) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    r_result <= w_result;
                    r_done   <= 1'b1;
                    r_busy   <= 1'b0;
                    r_state  <= S_DONE;
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.result = r_result;
endmodule
`default_nettype wire
